// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one program-memory read at a time, holds the
// returned instruction for decode, and handles redirects, misalignment and timeouts.
module instruction_fetch #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] pc,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic [31:0] pc_d,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    state_t        state_r,       state_s;
    logic          imem_req_r,    imem_req_s;
    logic [31:0]   imem_addr_r,   imem_addr_s;
    logic          instr_valid_r, instr_valid_s;
    logic [31:0]   instr_r,       instr_s;
    logic [31:0]   instr_pc_r,    instr_pc_s;
    logic          fault_r,       fault_s;
    logic          pc_ld_r,       pc_ld_s;
    logic          pc_inc_r,      pc_inc_s;
    logic [31:0]   pc_d_r,        pc_d_s;
    logic [CW-1:0] wait_cnt_r,    wait_cnt_s;
    logic          discard_r,     discard_s;

    // Next-state and next-output computation for every registered signal.
    always_comb begin
        state_s       = state_r;
        imem_req_s    = imem_req_r;
        imem_addr_s   = imem_addr_r;
        instr_valid_s = instr_valid_r;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        fault_s       = fault_r;
        pc_inc_s      = 1'b0;
        wait_cnt_s    = wait_cnt_r;
        discard_s     = discard_r;

        // A redirect overrides everything else this cycle, whatever the state.
        if (redirect) begin
            pc_ld_s       = 1'b1;
            pc_d_s        = redirect_addr;
            instr_valid_s = 1'b0;
            fault_s       = 1'b0;
        end else begin
            pc_ld_s = 1'b0;
            pc_d_s  = 32'd0;
        end

        case (state_r)
            IDLE: begin
                if (redirect) begin
                    state_s = IDLE;
                end else if (en && (pc[1:0] == 2'b00)) begin
                    state_s     = FETCH;
                    imem_req_s  = 1'b1;
                    imem_addr_s = pc;
                    wait_cnt_s  = '0;
                    discard_s   = 1'b0;
                end else if (en) begin
                    state_s = FAULT;
                    fault_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_rvalid) begin
                    imem_req_s = 1'b0;
                    wait_cnt_s = '0;
                    discard_s  = 1'b0;
                    // Data answering a redirected request is dropped without a PC step.
                    if (!redirect && !discard_r) begin
                        state_s       = HOLD;
                        instr_s       = imem_rdata;
                        instr_pc_s    = imem_addr_r;
                        instr_valid_s = 1'b1;
                        pc_ld_s       = 1'b1;
                        pc_inc_s      = 1'b1;
                        pc_d_s        = imem_addr_r;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (redirect) begin
                    discard_s = 1'b1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_s = wait_cnt_r;
                    end else begin
                        wait_cnt_s = wait_cnt_r + CW'(1);
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s    = FAULT;
                    fault_s    = 1'b1;
                    imem_req_s = 1'b0;
                    wait_cnt_s = '0;
                    discard_s  = 1'b0;
                end else begin
                    wait_cnt_s = wait_cnt_r + CW'(1);
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_s = IDLE;
                end else if (instr_ready) begin
                    state_s       = IDLE;
                    instr_valid_s = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            FAULT: begin
                if (redirect) begin
                    state_s = IDLE;
                end else begin
                    state_s = FAULT;
                end
            end
            default: begin
                state_s    = IDLE;
                imem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= 32'd0;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            fault_r       <= 1'b0;
            pc_ld_r       <= 1'b0;
            pc_inc_r      <= 1'b0;
            pc_d_r        <= 32'd0;
            wait_cnt_r    <= '0;
            discard_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            instr_valid_r <= instr_valid_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            fault_r       <= fault_s;
            pc_ld_r       <= pc_ld_s;
            pc_inc_r      <= pc_inc_s;
            pc_d_r        <= pc_d_s;
            wait_cnt_r    <= wait_cnt_s;
            discard_r     <= discard_s;
        end
    end

    assign pc_ld       = pc_ld_r;
    assign pc_inc      = pc_inc_r;
    assign pc_d        = pc_d_r;
    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch: each row gives one cycle of
// inputs and the outputs expected just after the following rising edge.
module tb_instruction_fetch;

    logic        clk;
    logic        clr;
    logic        en;
    logic [31:0] pc;
    logic        pc_ld;
    logic        pc_inc;
    logic [31:0] pc_d;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    int total_cnt = 0;
    int bad_cnt   = 0;

    instruction_fetch #(.MAX_WAIT(4)) dut (
        .clk(clk), .clr(clr), .en(en), .pc(pc),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_d(pc_d),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic        en;
        logic [31:0] pc;
        logic        rd;
        logic [31:0] rd_addr;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_ld;
        logic        e_inc;
        logic [31:0] e_pcd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string nm, input logic c, input logic e, input logic [31:0] p,
        input logic r, input logic [31:0] ra, input logic v, input logic [31:0] d,
        input logic y, input logic x_ld, input logic x_inc, input logic [31:0] x_pcd,
        input logic x_req, input logic [31:0] x_addr, input logic x_iv,
        input logic [31:0] x_instr, input logic [31:0] x_ipc, input logic x_fault);
        vec_t t;
        t.name = nm; t.clr = c; t.en = e; t.pc = p; t.rd = r; t.rd_addr = ra;
        t.rv = v; t.rdata = d; t.rdy = y; t.e_ld = x_ld; t.e_inc = x_inc;
        t.e_pcd = x_pcd; t.e_req = x_req; t.e_addr = x_addr; t.e_iv = x_iv;
        t.e_instr = x_instr; t.e_ipc = x_ipc; t.e_fault = x_fault;
        return t;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        clr = v.clr; en = v.en; pc = v.pc; redirect = v.rd; redirect_addr = v.rd_addr;
        imem_rvalid = v.rv; imem_rdata = v.rdata; instr_ready = v.rdy;
        @(posedge clk);
        #1;
        chk(v.name, "pc_ld",       {31'd0, pc_ld},       {31'd0, v.e_ld});
        chk(v.name, "pc_inc",      {31'd0, pc_inc},      {31'd0, v.e_inc});
        chk(v.name, "pc_d",        pc_d,                 v.e_pcd);
        chk(v.name, "imem_req",    {31'd0, imem_req},    {31'd0, v.e_req});
        chk(v.name, "imem_addr",   imem_addr,            v.e_addr);
        chk(v.name, "instr_valid", {31'd0, instr_valid}, {31'd0, v.e_iv});
        chk(v.name, "instr",       instr,                v.e_instr);
        chk(v.name, "instr_pc",    instr_pc,             v.e_ipc);
        chk(v.name, "fault",       {31'd0, fault},       {31'd0, v.e_fault});
    endtask

    initial begin
        //                 name          clr   en    pc            rd    rd_addr       rv    rdata          rdy   ld    inc   pc_d          req   addr          iv    instr          ipc           fault
        vecs.push_back(mk("reset",       1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("start_100",   1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk("wait_100",1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("rvalid_100",  1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("accept_100",  1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("start_104",   1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("redir_400",   1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("discard_104", 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("start_400",   1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0400, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
        vecs.push_back(mk("rvalid_400",  1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0400, 1'b1, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("backpress",1'b0, 1'b1, 32'h0000_0404, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0400, 1'b1, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        vecs.push_back(mk("accept_400",  1'b0, 1'b0, 32'h0000_0404, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0400, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        vecs.push_back(mk("en_low",      1'b0, 1'b0, 32'h0000_0404, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0400, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        vecs.push_back(mk("misalign",    1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0400, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b1));
        vecs.push_back(mk("fault_stick", 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0000, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0400, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b1));
        vecs.push_back(mk("redir_200",   1'b0, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0400, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        vecs.push_back(mk("start_200",   1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0200, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b0));
        vecs.push_back(mk("rvalid_200",  1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0));
        vecs.push_back(mk("accept_200",  1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0013, 32'h0000_0200, 1'b0));
        vecs.push_back(mk("start_204",   1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0013, 32'h0000_0200, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("tmo_wait",1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0013, 32'h0000_0200, 1'b0));
        vecs.push_back(mk("timeout",     1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0013, 32'h0000_0200, 1'b1));
        vecs.push_back(mk("late_rvalid", 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b1, 32'h00BA_DBAD, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0013, 32'h0000_0200, 1'b1));
        vecs.push_back(mk("clr_fault",   1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("start_300",   1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("clr_fetch",   1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("rvalid_aft",  1'b0, 1'b0, 32'h0000_0300, 1'b0, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("start_500",   1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("redir_rv",    1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600, 1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 32'h0000_0500, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("start_600",   1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0));
        vecs.push_back(mk("rvalid_600",  1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0000, 1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0600, 1'b1, 32'hAAAA_5555, 32'h0000_0600, 1'b0));
        vecs.push_back(mk("redir_hold",  1'b0, 1'b1, 32'h0000_0604, 1'b1, 32'h0000_0700, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 1'b0, 32'h0000_0600, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Redirect followed by a slow response: the discard must survive several idle cycles.
        run_vec(mk("d_start",  1'b0, 1'b1, 32'h0000_0700, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0700, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));
        run_vec(mk("d_redir",  1'b0, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 1'b1, 32'h0000_0700, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));
        for (int i = 0; i < 2; i++)
            run_vec(mk("d_wait", 1'b0, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0700, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));
        run_vec(mk("d_drop",   1'b0, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0700, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));
        run_vec(mk("d_next",   1'b0, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0800, 1'b0, 32'hAAAA_5555, 32'h0000_0600, 1'b0));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
